// File: rtl/lsu_issue_buffer.sv
// LSU issue buffer: in-order uop FIFO feeding a single-outstanding D-cache request/response FSM.
// Optional LSU_BYPASS_EN: an empty idle buffer forwards the issued uop to the D-cache in the same cycle.

package lsu_issue_buffer_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_load;
    logic [5:0]  tag;
    logic [31:0] addr;
  } uop_t;
endpackage

module lsu_issue_buffer
  import lsu_issue_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_en,
  input  uop_t              issue_info,
  output logic              lsu_busy,
  output logic              lsu_half_full,
  output logic              dc_req_valid,
  input  logic              dc_req_ready,
  output uop_t              dc_req_uop,
  input  logic              dc_resp_valid,
  input  logic [DATA_W-1:0] dc_resp_data,
  output logic              wb_valid,
  output uop_t              wb_uop,
  output logic [DATA_W-1:0] wb_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              wb_valid_q, wb_valid_d;
  uop_t              wb_uop_q, wb_uop_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  uop_t              mem_q [DEPTH];

  logic full, empty, push, pop, hs, req_valid_c;
  uop_t head, req_uop_c;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Request decode, FIFO bookkeeping, writeback capture and next state.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    wb_valid_d  = 1'b0;
    wb_uop_d    = '0;
    wb_data_d   = '0;
    req_valid_c = 1'b0;
    req_uop_c   = '0;

    if (state_q == S_IDLE) begin
      if (!empty) begin
        req_valid_c = 1'b1;
        req_uop_c   = head;
      end
`ifdef LSU_BYPASS_EN
      else if (issue_en && !flush) begin
        req_valid_c = 1'b1;
        req_uop_c   = issue_info;
      end
`endif
    end

    hs   = req_valid_c && dc_req_ready;
    pop  = (state_q == S_WAIT) && dc_resp_valid && !flush;
    // A full buffer still takes an issue when the head retires in the same cycle.
    push = issue_en && !flush && (!full || pop);

    unique case (state_q)
      S_IDLE:  if (hs) state_d = S_WAIT;
      S_WAIT:  if (dc_resp_valid) state_d = S_IDLE;
      S_DRAIN: if (dc_resp_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      wb_valid_d = 1'b1;
      wb_uop_d   = head;
      wb_data_d  = head.is_load ? dc_resp_data : '0;
    end

    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      // Any request still in flight must have its response swallowed.
      if ((state_q != S_IDLE || hs) && !dc_resp_valid) state_d = S_DRAIN;
      else                                             state_d = S_IDLE;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_uop_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_uop_q   <= wb_uop_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= issue_info;
  end

  assign lsu_busy      = full;
  assign lsu_half_full = (count_q >= CNT_W'(DEPTH / 2));
  assign dc_req_valid  = req_valid_c;
  assign dc_req_uop    = req_uop_c;
  assign wb_valid      = wb_valid_q;
  assign wb_uop        = wb_uop_q;
  assign wb_data       = wb_data_q;

  a_no_drop: assert property (@(posedge clk) disable iff (!rst)
    !(issue_en && !flush && full && !pop));
  a_no_idle_resp: assert property (@(posedge clk) disable iff (!rst)
    !(state_q == S_IDLE && dc_resp_valid));

endmodule

// File: tb/tb_lsu_issue_buffer.sv
// Directed bench for lsu_issue_buffer; writebacks are checked against a queue of expected results.
module tb_lsu_issue_buffer;
  import lsu_issue_buffer_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam logic [63:0] ST_IDLE  = 64'd0;
  localparam logic [63:0] ST_WAIT  = 64'd1;
  localparam logic [63:0] ST_DRAIN = 64'd2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              issue_en = 1'b0;
  uop_t              issue_info = '0;
  logic              lsu_busy, lsu_half_full;
  logic              dc_req_valid;
  logic              dc_req_ready = 1'b0;
  uop_t              dc_req_uop;
  logic              dc_resp_valid = 1'b0;
  logic [DATA_W-1:0] dc_resp_data = '0;
  logic              wb_valid;
  uop_t              wb_uop;
  logic [DATA_W-1:0] wb_data;

  typedef struct packed {
    uop_t              uop;
    logic [DATA_W-1:0] data;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  lsu_issue_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_en(issue_en), .issue_info(issue_info),
    .lsu_busy(lsu_busy), .lsu_half_full(lsu_half_full),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_uop(dc_req_uop),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .wb_valid(wb_valid), .wb_uop(wb_uop), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic uop_t mk(input logic [5:0] tag, input logic is_load);
    uop_t u;
    u.valid   = 1'b1;
    u.is_load = is_load;
    u.tag     = tag;
    u.addr    = 32'h1000 + {24'h0, 2'b00, tag, 2'b00};
    return u;
  endfunction

  task automatic expect_wb(input uop_t u, input logic [DATA_W-1:0] d);
    wb_exp_t e;
    e.uop  = u;
    e.data = u.is_load ? d : '0;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Every writeback strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && wb_valid) begin
      chk("wb_expected", 64'(wb_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        wb_exp_t e;
        e = exp_q.pop_front();
        chk("wb_uop", 64'(wb_uop), 64'(e.uop));
        chk("wb_data", 64'(wb_data), 64'(e.data));
      end
    end
  end

  initial begin
    uop_t ua, u[0:4], u6, u7, u8, u9, u10, u11, u12;
    ua  = mk(6'h0A, 1'b1);
    u[0] = mk(6'h01, 1'b1);
    u[1] = mk(6'h02, 1'b0);
    u[2] = mk(6'h03, 1'b1);
    u[3] = mk(6'h04, 1'b1);
    u[4] = mk(6'h05, 1'b1);
    u6  = mk(6'h06, 1'b1);
    u7  = mk(6'h07, 1'b1);
    u8  = mk(6'h08, 1'b1);
    u9  = mk(6'h09, 1'b1);
    u10 = mk(6'h10, 1'b1);
    u11 = mk(6'h11, 1'b0);
    u12 = mk(6'h12, 1'b1);

    // reset state
    cyc(); cyc();
    chk("rst_req_valid", 64'(dc_req_valid), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_busy", 64'(lsu_busy), 64'd0);
    rst = 1'b1;
    cyc();

    // single load round trip
    issue_en = 1'b1; issue_info = ua;
    cyc();
    issue_en = 1'b0; dc_req_ready = 1'b1;
    #1;
    chk("t2_req_valid", 64'(dc_req_valid), 64'd1);
    chk("t2_req_uop", 64'(dc_req_uop), 64'(ua));
    cyc();
    dc_req_ready = 1'b0;
    chk("t2_state_wait", 64'(dut.state_q), ST_WAIT);
    chk("t2_req_quiet", 64'(dc_req_valid), 64'd0);
    cyc();
    dc_resp_valid = 1'b1; dc_resp_data = 32'hDEADBEEF;
    expect_wb(ua, 32'hDEADBEEF);
    cyc();
    dc_resp_valid = 1'b0;
    chk("t2_wb_valid", 64'(wb_valid), 64'd1);
    chk("t2_wb_data", 64'(wb_data), 64'hDEADBEEF);
    chk("t2_count", 64'(dut.count_q), 64'd0);
    chk("t2_state_idle", 64'(dut.state_q), ST_IDLE);

    // fill to DEPTH with requests stalled
    for (int i = 0; i < 4; i++) begin
      issue_en = 1'b1; issue_info = u[i];
      cyc();
      chk("t3_half_full", 64'(lsu_half_full), 64'((i + 1) >= 2));
      chk("t3_busy", 64'(lsu_busy), 64'((i + 1) == 4));
    end
    issue_en = 1'b0; dc_req_ready = 1'b1;
    #1;
    chk("t3_req_head", 64'(dc_req_uop), 64'(u[0]));
    cyc();
    dc_req_ready = 1'b0;
    chk("t3_state_wait", 64'(dut.state_q), ST_WAIT);
    dc_resp_valid = 1'b1; dc_resp_data = 32'h11110001;
    issue_en = 1'b1; issue_info = u[4];
    expect_wb(u[0], 32'h11110001);
    cyc();
    dc_resp_valid = 1'b0; issue_en = 1'b0;
    chk("t3_count_held", 64'(dut.count_q), 64'd4);
    chk("t3_busy_held", 64'(lsu_busy), 64'd1);
    dc_req_ready = 1'b1;
    #1;
    chk("t3_req_second", 64'(dc_req_uop), 64'(u[1]));
    cyc();
    dc_req_ready = 1'b0;
    dc_resp_valid = 1'b1; dc_resp_data = 32'hCAFEF00D;
    expect_wb(u[1], 32'hCAFEF00D);
    cyc();
    dc_resp_valid = 1'b0;
    chk("t3_store_wb_zero", 64'(wb_data), 64'd0);
    chk("t3_count3", 64'(dut.count_q), 64'd3);
    dc_req_ready = 1'b1;
    cyc();
    dc_req_ready = 1'b0;
    chk("t4_pre_wait", 64'(dut.state_q), ST_WAIT);

    // flush in WAIT with three queued
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t4_count0", 64'(dut.count_q), 64'd0);
    chk("t4_state_drain", 64'(dut.state_q), ST_DRAIN);
    chk("t4_half_clear", 64'(lsu_half_full), 64'd0);
    issue_en = 1'b1; issue_info = u6; dc_req_ready = 1'b1;
    #1;
    chk("t4_no_req_in_drain", 64'(dc_req_valid), 64'd0);
    cyc();
    issue_en = 1'b0;
    chk("t4_drain_accepts", 64'(dut.count_q), 64'd1);
    chk("t4_still_no_req", 64'(dc_req_valid), 64'd0);
    dc_resp_valid = 1'b1; dc_resp_data = 32'h66666666;
    cyc();
    dc_resp_valid = 1'b0;
    chk("t4_no_wb", 64'(wb_valid), 64'd0);
    chk("t4_back_idle", 64'(dut.state_q), ST_IDLE);
    chk("t4_req_after_idle", 64'(dc_req_valid), 64'd1);
    chk("t4_req_uop", 64'(dc_req_uop), 64'(u6));
    cyc();
    dc_req_ready = 1'b0;
    chk("t4_wait", 64'(dut.state_q), ST_WAIT);
    dc_resp_valid = 1'b1; dc_resp_data = 32'h0000600D;
    expect_wb(u6, 32'h0000600D);
    cyc();
    dc_resp_valid = 1'b0;
    chk("t4_count_end", 64'(dut.count_q), 64'd0);

    // flush together with an idle handshake
    issue_en = 1'b1; issue_info = u7;
    cyc();
    issue_en = 1'b0;
    chk("t5_req_valid", 64'(dc_req_valid), 64'd1);
    dc_req_ready = 1'b1; flush = 1'b1;
    cyc();
    dc_req_ready = 1'b0; flush = 1'b0;
    chk("t5_hs_drain", 64'(dut.state_q), ST_DRAIN);
    chk("t5_hs_count", 64'(dut.count_q), 64'd0);
    dc_resp_valid = 1'b1; dc_resp_data = 32'h77777777;
    cyc();
    dc_resp_valid = 1'b0;
    chk("t5_drain_no_wb", 64'(wb_valid), 64'd0);
    chk("t5_drain_idle", 64'(dut.state_q), ST_IDLE);

    // flush together with the response in WAIT
    issue_en = 1'b1; issue_info = u8;
    cyc();
    issue_en = 1'b0; dc_req_ready = 1'b1;
    cyc();
    dc_req_ready = 1'b0;
    chk("t5b_wait", 64'(dut.state_q), ST_WAIT);
    dc_resp_valid = 1'b1; dc_resp_data = 32'h88888888; flush = 1'b1;
    cyc();
    dc_resp_valid = 1'b0; flush = 1'b0;
    chk("t5b_idle", 64'(dut.state_q), ST_IDLE);
    chk("t5b_no_wb", 64'(wb_valid), 64'd0);
    chk("t5b_count", 64'(dut.count_q), 64'd0);

    // issue-to-request latency
    issue_en = 1'b1; issue_info = u9; dc_req_ready = 1'b1;
    #1;
`ifdef LSU_BYPASS_EN
    chk("t6_byp_req_same", 64'(dc_req_valid), 64'd1);
    chk("t6_byp_uop", 64'(dc_req_uop), 64'(u9));
    cyc();
    issue_en = 1'b0; dc_req_ready = 1'b0;
    chk("t6_byp_wait", 64'(dut.state_q), ST_WAIT);
`else
    chk("t6_req_not_same", 64'(dc_req_valid), 64'd0);
    cyc();
    issue_en = 1'b0;
    chk("t6_req_next", 64'(dc_req_valid), 64'd1);
    chk("t6_idle", 64'(dut.state_q), ST_IDLE);
    cyc();
    dc_req_ready = 1'b0;
    chk("t6_wait", 64'(dut.state_q), ST_WAIT);
`endif
    dc_resp_valid = 1'b1; dc_resp_data = 32'h99990009;
    expect_wb(u9, 32'h99990009);
    cyc();
    dc_resp_valid = 1'b0;
    chk("t6_count", 64'(dut.count_q), 64'd0);

    // asynchronous reset mid-WAIT with three queued
    issue_en = 1'b1; issue_info = u10; cyc();
    issue_info = u11; cyc();
    issue_info = u12; cyc();
    issue_en = 1'b0; dc_req_ready = 1'b1;
    cyc();
    dc_req_ready = 1'b0;
    chk("t1_pre_wait", 64'(dut.state_q), ST_WAIT);
    chk("t1_pre_count", 64'(dut.count_q), 64'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("t1_state", 64'(dut.state_q), ST_IDLE);
    chk("t1_count", 64'(dut.count_q), 64'd0);
    chk("t1_half", 64'(lsu_half_full), 64'd0);
    chk("t1_req", 64'(dc_req_valid), 64'd0);
    chk("t1_wb", 64'(wb_valid), 64'd0);
    chk("t1_wb_data", 64'(wb_data), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("t1_rel_busy", 64'(lsu_busy), 64'd0);
    chk("t1_rel_half", 64'(lsu_half_full), 64'd0);

    cyc(); cyc();
    chk("all_wb_seen", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
